sram_scan_ctrl: RTL

User-project responder for the GPIO scan protocol driven off-chip on mprj_io[15:22]. It shifts in a 112-bit command frame and, on a global chip-select strobe, issues one access to the selected OpenRAM test macro. It captures the read data and reloads it into the frame, which is then shifted back out. It sits between the GPIO pads and the SRAM macro array in the user project wrapper.

---
 rtl/sram_scan_pkg.sv | 65 ++++++
 rtl/sram_scan_shreg.sv | 40 ++++
 rtl/sram_scan_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_scan_pkg.sv
// Shared frame layout, field offsets and sel decode for the GPIO scan SRAM responder.
package sram_scan_pkg;

    localparam int unsigned FRAME_W     = 112;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WMASK_W     = 4;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned SEL_SP_BASE = 8;

    localparam int unsigned WMASK1_LSB  = 0;
    localparam int unsigned WEB1_BIT    = 4;
    localparam int unsigned CSB1_BIT    = 5;
    localparam int unsigned DIN1_LSB    = 6;
    localparam int unsigned ADDR1_LSB   = 38;
    localparam int unsigned WMASK0_LSB  = 54;
    localparam int unsigned WEB0_BIT    = 58;
    localparam int unsigned CSB0_BIT    = 59;
    localparam int unsigned DIN0_LSB    = 60;
    localparam int unsigned ADDR0_LSB   = 92;
    localparam int unsigned SEL_LSB     = 108;

    typedef struct packed {
        logic [SEL_W-1:0]   sel;
        logic [ADDR_W-1:0]  addr0;
        logic [DATA_W-1:0]  din0;
        logic               csb0;
        logic               web0;
        logic [WMASK_W-1:0] wmask0;
        logic [ADDR_W-1:0]  addr1;
        logic [DATA_W-1:0]  din1;
        logic               csb1;
        logic               web1;
        logic [WMASK_W-1:0] wmask1;
    } frame_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } sel_idx_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_e;

    // Dual-port macros sit at sel 0..num_dp-1, single-port at SEL_SP_BASE upward.
    function automatic sel_idx_t sel2idx(input logic [SEL_W-1:0] sel,
                                         input int unsigned num_dp,
                                         input int unsigned num_sp);
        sel_idx_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        if (32'(sel) < num_dp) begin
            r.valid = 1'b1;
            r.idx   = IDX_W'(sel);
        end else if (32'(sel) >= SEL_SP_BASE && 32'(sel) < SEL_SP_BASE + num_sp) begin
            r.valid = 1'b1;
            r.idx   = IDX_W'(32'(sel) - SEL_SP_BASE + num_dp);
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_scan_shreg.sv
// 112-bit scan frame: serial shift (MSB out first) with parallel reload of the din fields.
module sram_scan_shreg
    import sram_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en_i,
    input  logic               scan_in_i,
    input  logic               load_en_i,
    input  logic               ld0_en_i,
    input  logic [DATA_W-1:0]  ld0_data_i,
    input  logic               ld1_en_i,
    input  logic [DATA_W-1:0]  ld1_data_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               scan_out_o
);

    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;

    // Shift wins over load; a load only touches din fields whose read was valid.
    always_comb begin
        frame_d = frame_q;
        if (shift_en_i) begin
            frame_d = {frame_q[FRAME_W-2:0], scan_in_i};
        end else if (load_en_i) begin
            if (ld0_en_i) frame_d[DIN0_LSB +: DATA_W] = ld0_data_i;
            if (ld1_en_i) frame_d[DIN1_LSB +: DATA_W] = ld1_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_q <= '0;
        else        frame_q <= frame_d;
    end

    assign frame_o    = frame_q;
    assign scan_out_o = frame_q[FRAME_W-1];

endmodule

// File: rtl/sram_scan_ctrl.sv
// GPIO scan responder: one SRAM macro access per global_csb falling edge, read data captured for scan-back.
// Optional build macro SRAM_SCAN_BADSEL_EN adds the sticky err_badsel output and tagged unmapped reads.
module sram_scan_ctrl
    import sram_scan_pkg::*;
#(
    parameter  int unsigned NUM_DP  = 5,
    parameter  int unsigned NUM_SP  = 4,
    localparam int unsigned NUM_MEM = NUM_DP + NUM_SP
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      scan_en,
    input  logic                      scan_in,
    input  logic                      sram_load,
    input  logic                      global_csb,
    output logic                      scan_out,
`ifdef SRAM_SCAN_BADSEL_EN
    output logic                      err_badsel,
`endif
    output logic [NUM_MEM-1:0]        mem_csb0,
    output logic [NUM_MEM-1:0]        mem_csb1,
    output logic                      mem_web0,
    output logic                      mem_web1,
    output logic [WMASK_W-1:0]        mem_wmask0,
    output logic [WMASK_W-1:0]        mem_wmask1,
    output logic [ADDR_W-1:0]         mem_addr0,
    output logic [ADDR_W-1:0]         mem_addr1,
    output logic [DATA_W-1:0]         mem_din0,
    output logic [DATA_W-1:0]         mem_din1,
    input  logic [NUM_MEM*DATA_W-1:0] mem_dout0,
    input  logic [NUM_MEM*DATA_W-1:0] mem_dout1
);

    logic [FRAME_W-1:0] frame;
    frame_t             fr;
    sel_idx_t           sel_dec;
    logic               acc;

    state_e             state_q, state_d;
    logic               csb_q;
    sel_idx_t           acc_sel_q, acc_sel_d;
    logic               rd0_req_q, rd0_req_d;
    logic               rd1_req_q, rd1_req_d;
    logic [DATA_W-1:0]  dout0_q, dout0_d;
    logic [DATA_W-1:0]  dout1_q, dout1_d;
    logic               rd0_v_q, rd0_v_d;
    logic               rd1_v_q, rd1_v_d;
    logic               ld0_en, ld1_en;
    logic [DATA_W-1:0]  ld0_data, ld1_data;
`ifdef SRAM_SCAN_BADSEL_EN
    localparam logic [DATA_W-1:0] BADSEL_TAG = 32'hBADC0DE0;
    logic [SEL_W-1:0]   acc_raw_q, acc_raw_d;
    logic               err_q, err_d;
`endif

    assign fr      = frame_t'(frame);
    assign sel_dec = sel2idx(fr.sel, NUM_DP, NUM_SP);

    // csb_q edge detect limits us to one access per falling edge of global_csb.
    assign acc = !global_csb && csb_q && !scan_en && (state_q == ST_IDLE) && resetn;

    assign mem_addr0  = frame[ADDR0_LSB +: ADDR_W];
    assign mem_din0   = frame[DIN0_LSB +: DATA_W];
    assign mem_web0   = frame[WEB0_BIT];
    assign mem_wmask0 = frame[WMASK0_LSB +: WMASK_W];
    assign mem_addr1  = frame[ADDR1_LSB +: ADDR_W];
    assign mem_din1   = frame[DIN1_LSB +: DATA_W];
    assign mem_web1   = frame[WEB1_BIT];
    assign mem_wmask1 = frame[WMASK1_LSB +: WMASK_W];

    always_comb begin
        mem_csb0 = '1;
        mem_csb1 = '1;
        if (acc && sel_dec.valid) begin
            for (int unsigned i = 0; i < NUM_MEM; i++) begin
                if (sel_dec.idx == IDX_W'(i)) begin
                    mem_csb0[i] = fr.csb0;
                    if (i < NUM_DP) mem_csb1[i] = fr.csb1;
                end
            end
        end
    end

    // Access context is latched at E0 so shifting during CAPTURE cannot disturb it.
    always_comb begin
        state_d   = state_q;
        acc_sel_d = acc_sel_q;
        rd0_req_d = rd0_req_q;
        rd1_req_d = rd1_req_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;
        rd0_v_d   = rd0_v_q;
        rd1_v_d   = rd1_v_q;
`ifdef SRAM_SCAN_BADSEL_EN
        acc_raw_d = acc_raw_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d   = ST_CAPTURE;
                    acc_sel_d = sel_dec;
                    rd0_req_d = !fr.csb0 && fr.web0;
                    rd1_req_d = !fr.csb1 && fr.web1 && (32'(sel_dec.idx) < NUM_DP);
`ifdef SRAM_SCAN_BADSEL_EN
                    acc_raw_d = fr.sel;
                    if (!sel_dec.valid) err_d = 1'b1;
`endif
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                dout0_d = '0;
                dout1_d = '0;
                rd0_v_d = 1'b0;
                rd1_v_d = 1'b0;
                if (acc_sel_q.valid) begin
                    for (int unsigned i = 0; i < NUM_MEM; i++) begin
                        if (acc_sel_q.idx == IDX_W'(i)) begin
                            dout0_d = mem_dout0[i*DATA_W +: DATA_W];
                            dout1_d = mem_dout1[i*DATA_W +: DATA_W];
                        end
                    end
                    rd0_v_d = rd0_req_q;
                    rd1_v_d = rd1_req_q;
                end
`ifdef SRAM_SCAN_BADSEL_EN
                else begin
                    dout0_d = BADSEL_TAG | DATA_W'(acc_raw_q);
                    dout1_d = BADSEL_TAG | DATA_W'(acc_raw_q);
                    rd0_v_d = 1'b1;
                    rd1_v_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A load coinciding with the capture edge sees the value being captured.
    always_comb begin
        ld0_en   = rd0_v_q;
        ld1_en   = rd1_v_q;
        ld0_data = dout0_q;
        ld1_data = dout1_q;
        if (state_q == ST_CAPTURE) begin
            ld0_en   = rd0_v_d;
            ld1_en   = rd1_v_d;
            ld0_data = dout0_d;
            ld1_data = dout1_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            csb_q     <= 1'b1;
            acc_sel_q <= '0;
            rd0_req_q <= 1'b0;
            rd1_req_q <= 1'b0;
            dout0_q   <= '0;
            dout1_q   <= '0;
            rd0_v_q   <= 1'b0;
            rd1_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            csb_q     <= global_csb;
            acc_sel_q <= acc_sel_d;
            rd0_req_q <= rd0_req_d;
            rd1_req_q <= rd1_req_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            rd0_v_q   <= rd0_v_d;
            rd1_v_q   <= rd1_v_d;
        end
    end

`ifdef SRAM_SCAN_BADSEL_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_raw_q <= '0;
            err_q     <= 1'b0;
        end else begin
            acc_raw_q <= acc_raw_d;
            err_q     <= err_d;
        end
    end

    assign err_badsel = err_q;
`endif

    sram_scan_shreg u_shreg (
        .clk        (clk),
        .rst_n      (resetn),
        .shift_en_i (scan_en),
        .scan_in_i  (scan_in),
        .load_en_i  (sram_load && !scan_en),
        .ld0_en_i   (ld0_en),
        .ld0_data_i (ld0_data),
        .ld1_en_i   (ld1_en),
        .ld1_data_i (ld1_data),
        .frame_o    (frame),
        .scan_out_o (scan_out)
    );

endmodule
